// File: rtl/seq_ctrl.sv
// Purpose : fetch/execute sequencer for the 9-bit-instruction core (PC, IR, branch flag, commit strobe).
// Latency : 2 cycles per non-memory instruction (FETCH+EXEC), 2+N for ld/st with N-cycle Mem_ack latency.
// Backpr. : Mem_req held until Mem_ack with no timeout; Start honoured only in IDLE/DONE.
//
// Ports:
//   Clk, Reset_n       clock (rising edge) and asynchronous active-low reset
//   Start              begin program at PC 0 (IDLE/DONE only)
//   Instr              combinational instruction ROM data at address PC
//   Cmp                ALU compare result, valid while IR holds blt/beq
//   JTarget            jump-table entry selected by Jptr
//   Mem_ack            data-memory completion
//   PC, IR, Jptr, Jen  program counter, instruction register, jump index, branch flag
//   Exec_en            one-cycle commit strobe gating register/data-memory writes
//   Mem_req            data-memory request
//   Busy, Done         run status
//   InstrCnt           retired instructions since last Start, saturating
module seq_ctrl #(
    parameter int          PC_W      = 10,
    parameter int          CNT_W     = 16,
    parameter logic [8:0]  HALT_CODE = 9'h1C0
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [8:0]       Instr,
    input  logic             Cmp,
    input  logic [PC_W-1:0]  JTarget,
    input  logic             Mem_ack,
    output logic [PC_W-1:0]  PC,
    output logic [8:0]       IR,
    output logic [4:0]       Jptr,
    output logic             Jen,
    output logic             Exec_en,
    output logic             Mem_req,
    output logic             Busy,
    output logic             Done,
    output logic [CNT_W-1:0] InstrCnt
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_FETCH   = 3'd1;
    localparam logic [2:0] ST_EXEC    = 3'd2;
    localparam logic [2:0] ST_MEMWAIT = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    localparam logic [2:0] OP_LDST = 3'b000;
    localparam logic [2:0] OP_JMP  = 3'b100;
    localparam logic [2:0] OP_BLT  = 3'b101;
    localparam logic [2:0] OP_BEQ  = 3'b110;

    logic [2:0]       state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [8:0]       ir_q, ir_d;
    logic             jen_q, jen_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [2:0]       opcode;
    logic             is_halt;
    logic             is_ldst;
    logic             is_branch;
    logic             is_jump;
    logic             in_exec;
    logic             in_memwait;
    logic             commit;
    logic [PC_W-1:0]  pc_inc;

    // Decode of the latched instruction. HALT is tested first so that its
    // encoding never aliases onto another opcode class.
    assign opcode    = ir_q[8:6];
    assign is_halt   = (ir_q == HALT_CODE);
    assign is_ldst   = !is_halt && (opcode == OP_LDST);
    assign is_branch = !is_halt && ((opcode == OP_BLT) || (opcode == OP_BEQ));
    assign is_jump   = !is_halt && (opcode == OP_JMP);

    assign in_exec    = (state_q == ST_EXEC);
    assign in_memwait = (state_q == ST_MEMWAIT);

    // Commit: EXEC for every non-halt, non-memory instruction; the ack cycle
    // for ld/st. This is the only place Exec_en can be high, so each
    // instruction writes the register file / data memory at most once.
    assign commit = (in_exec && !is_halt && !is_ldst) || (in_memwait && Mem_ack);

    // PC wraps naturally at 2**PC_W.
    assign pc_inc = pc_q + PC_W'(1);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        jen_d   = jen_q;
        cnt_d   = cnt_q;

        // Saturating retire counter, stepped once per committed instruction.
        if (commit && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                pc_d  = '0;
                jen_d = 1'b0;
                cnt_d = '0;
                if (Start) begin
                    state_d = ST_FETCH;
                end
            end

            ST_FETCH: begin
                ir_d    = Instr;
                state_d = ST_EXEC;
            end

            ST_EXEC: begin
                state_d = ST_FETCH;
                if (is_halt) begin
                    state_d = ST_DONE;
                end else if (is_ldst) begin
                    state_d = ST_MEMWAIT;
                end else if (is_branch) begin
                    jen_d = Cmp;
                    pc_d  = pc_inc;
                end else if (is_jump) begin
                    if (ir_q[5]) begin
                        // Unconditional: flag left untouched.
                        pc_d = JTarget;
                    end else begin
                        // Conditional: flag is consumed whether or not taken.
                        pc_d  = jen_q ? JTarget : pc_inc;
                        jen_d = 1'b0;
                    end
                end else begin
                    pc_d = pc_inc;
                end
            end

            ST_MEMWAIT: begin
                if (Mem_ack) begin
                    pc_d    = pc_inc;
                    state_d = ST_FETCH;
                end
            end

            ST_DONE: begin
                // Restart behaves exactly like a Start from IDLE.
                if (Start) begin
                    pc_d    = '0;
                    jen_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_FETCH;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            jen_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            jen_q   <= jen_d;
            cnt_q   <= cnt_d;
        end
    end

    // Mem_req is decoded from state so it falls the instant reset asserts,
    // and drops combinationally in the ack cycle.
    assign Mem_req  = (in_exec && is_ldst) || (in_memwait && !Mem_ack);
    assign Exec_en  = commit;
    assign Busy     = (state_q == ST_FETCH) || in_exec || in_memwait;
    assign Done     = (state_q == ST_DONE);
    assign PC       = pc_q;
    assign IR       = ir_q;
    assign Jptr     = ir_q[4:0];
    assign Jen      = jen_q;
    assign InstrCnt = cnt_q;

endmodule
